// File: rtl/memwr_port_bank.sv
// memwr_port_bank
//   Small multi-channel register array. A fill sequence writes FILL_VAL to
//   every entry after reset and again on init_req. Each channel has its own
//   write port and registered read port, and collisions are flagged.
//
//   Optional build macro: MEMWR_LANE_EN. When it is defined, the wr_lane
//   port exists, writes are masked per sub-word lane, and collisions are
//   detected per lane. When it is undefined, every write replaces the whole
//   word.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   init_req   in   re-run the fill sequence (ignored while it runs)
//   init_busy  out  fill sequence running
//   wr_valid   in   [NCH]        per-channel write strobe
//   wr_addr    in   [NCH*AW]     per-channel write address
//   wr_data    in   [NCH*WIDTH]  per-channel write data
//   wr_lane    in   [NCH*LANES]  per-channel lane enables (MEMWR_LANE_EN only)
//   wr_ready   out  writes are accepted (IDLE)
//   rd_addr    in   [NCH*AW]     per-channel read address
//   rd_data    out  [NCH*WIDTH]  per-channel read data, one cycle latency
//   conflict   out  pulse: overlapping accepted writes in the previous cycle
//
// state | meaning
// ------+----------------------------------------------------------
// FILL  | writing FILL_VAL to entry fill_ptr, user writes dropped
// IDLE  | user writes accepted, init_req starts a new fill
module memwr_port_bank #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int NCH   = 2,
  parameter int LANES = 2,
  parameter logic [WIDTH-1:0] FILL_VAL = 4'hA,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_req,
  output logic                 init_busy,
  input  logic [NCH-1:0]       wr_valid,
  input  logic [NCH*AW-1:0]    wr_addr,
  input  logic [NCH*WIDTH-1:0] wr_data,
`ifdef MEMWR_LANE_EN
  input  logic [NCH*LANES-1:0] wr_lane,
`endif
  output logic                 wr_ready,
  input  logic [NCH*AW-1:0]    rd_addr,
  output logic [NCH*WIDTH-1:0] rd_data,
  output logic                 conflict
);

  if (WIDTH % LANES != 0) begin : g_lane_check
    $error("memwr_port_bank: WIDTH must be divisible by LANES");
  end

  typedef enum logic {FILL, IDLE} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    fill_ptr, fill_ptr_nxt;
  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] mem_nxt [DEPTH];
  logic [AW-1:0]    waddr   [NCH];
  logic [AW-1:0]    raddr   [NCH];
  logic [WIDTH-1:0] wdata   [NCH];
  logic [WIDTH-1:0] bmask   [NCH];
  logic [NCH-1:0]   accept;
  logic             conflict_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      fill_ptr <= '0;
    end else begin
      state    <= state_nxt;
      fill_ptr <= fill_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fill_ptr_nxt = fill_ptr;
    init_busy    = 1'b0;
    wr_ready     = 1'b0;
    case (state)
      FILL: begin
        init_busy = 1'b1;
        if (fill_ptr == AW'(DEPTH - 1)) begin
          state_nxt    = IDLE;
          fill_ptr_nxt = '0;
        end else begin
          fill_ptr_nxt = fill_ptr + 1'b1;
        end
      end
      IDLE: begin
        wr_ready = 1'b1;
        if (init_req) begin
          state_nxt    = FILL;
          fill_ptr_nxt = '0;
        end
      end
    endcase
  end

  // Per-channel unpacking, write bit-mask and acceptance.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      waddr[c]  = wr_addr[c*AW +: AW];
      raddr[c]  = rd_addr[c*AW +: AW];
      wdata[c]  = wr_data[c*WIDTH +: WIDTH];
`ifdef MEMWR_LANE_EN
      for (int l = 0; l < LANES; l++)
        bmask[c][l*(WIDTH/LANES) +: (WIDTH/LANES)] = {(WIDTH/LANES){wr_lane[c*LANES + l]}};
`else
      bmask[c]  = '1;
`endif
      accept[c] = (state == IDLE) && wr_valid[c] && (32'(waddr[c]) < 32'(DEPTH));
    end
  end

  // Channels are applied in ascending order so the highest-numbered channel
  // owns any bit written by more than one channel.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_nxt[i] = mem[i];
    if (state == FILL) begin
      mem_nxt[fill_ptr] = FILL_VAL;
    end else begin
      for (int c = 0; c < NCH; c++)
        if (accept[c])
          mem_nxt[waddr[c]] = (mem_nxt[waddr[c]] & ~bmask[c]) | (wdata[c] & bmask[c]);
    end
  end

  // Lanes occupy disjoint bits, so overlapping bit-masks means a shared lane.
  always_comb begin
    conflict_nxt = 1'b0;
    for (int i = 0; i < NCH; i++)
      for (int j = i + 1; j < NCH; j++)
        if (accept[i] && accept[j] && (waddr[i] == waddr[j]) && |(bmask[i] & bmask[j]))
          conflict_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data  <= '0;
      conflict <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_nxt[i];
      for (int c = 0; c < NCH; c++)
        rd_data[c*WIDTH +: WIDTH] <= (32'(raddr[c]) < 32'(DEPTH)) ? mem[raddr[c]] : '0;
      conflict <= conflict_nxt;
    end
  end

endmodule

// File: tb/tb_memwr_port_bank.sv
module tb_memwr_port_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_req;
  logic       init_busy;
  logic [1:0] wr_valid;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] wr_lane;
  logic       wr_ready;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       conflict;

  logic       b_init_req;
  logic       b_init_busy;
  logic [0:0] b_wr_valid;
  logic [1:0] b_wr_addr;
  logic [3:0] b_wr_data;
  logic [1:0] b_wr_lane;
  logic       b_wr_ready;
  logic [1:0] b_rd_addr;
  logic [3:0] b_rd_data;
  logic       b_conflict;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memwr_port_bank dut (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_busy(init_busy),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef MEMWR_LANE_EN
    .wr_lane(wr_lane),
`endif
    .wr_ready(wr_ready), .rd_addr(rd_addr), .rd_data(rd_data), .conflict(conflict)
  );

  // Three-entry, single-channel instance: exercises addresses >= DEPTH.
  memwr_port_bank #(.DEPTH(3), .NCH(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .init_req(b_init_req), .init_busy(b_init_busy),
    .wr_valid(b_wr_valid), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
`ifdef MEMWR_LANE_EN
    .wr_lane(b_wr_lane),
`endif
    .wr_ready(b_wr_ready), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .conflict(b_conflict)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    init_req = 0; wr_valid = 0; wr_addr = 0; wr_data = 0; wr_lane = 4'b1111; rd_addr = 0;
    b_init_req = 0; b_wr_valid = 0; b_wr_addr = 0; b_wr_data = 0; b_wr_lane = 2'b11; b_rd_addr = 0;
    rst_n = 0;
    step(); step();
    checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%0b exp=1", init_busy); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", wr_ready); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL reset_conflict got=%0b exp=0", conflict); end
    rst_n = 1;
    #1;
    checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL fill_busy0 got=%0b exp=1", init_busy); end
    step();
    checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL fill_busy1 got=%0b exp=1", init_busy); end
    step();
    checks++; if (init_busy !== 1'b0) begin failures++; $display("FAIL fill_done_busy got=%0b exp=0", init_busy); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL fill_done_ready got=%0b exp=1", wr_ready); end
    checks++; if (b_init_busy !== 1'b1) begin failures++; $display("FAIL b_fill_busy2 got=%0b exp=1", b_init_busy); end
    step();
    checks++; if (b_init_busy !== 1'b0) begin failures++; $display("FAIL b_fill_done got=%0b exp=0", b_init_busy); end
    rd_addr = 2'b10; b_rd_addr = 2'd2;
    step();
    checks++; if (rd_data !== 8'hAA) begin failures++; $display("FAIL fill_read got=%h exp=aa", rd_data); end
    checks++; if (b_rd_data !== 4'hA) begin failures++; $display("FAIL b_fill_read got=%h exp=a", b_rd_data); end
  endtask

  task automatic test_parallel_write();
    wr_valid = 2'b11; wr_addr = 2'b10; wr_data = 8'h53;
    step();
    wr_valid = 2'b00; rd_addr = 2'b10;
    checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL par_conflict got=%0b exp=0", conflict); end
    step();
    checks++; if (rd_data !== 8'h53) begin failures++; $display("FAIL par_read got=%h exp=53", rd_data); end
    checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL par_conflict2 got=%0b exp=0", conflict); end
  endtask

  task automatic test_collision();
    wr_valid = 2'b11; wr_addr = 2'b11; wr_data = 8'h71;
    step();
    checks++; if (conflict !== 1'b1) begin failures++; $display("FAIL coll_pulse got=%0b exp=1", conflict); end
    wr_valid = 2'b00; rd_addr = 2'b11;
    step();
    checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL coll_pulse_end got=%0b exp=0", conflict); end
    checks++; if (rd_data !== 8'h77) begin failures++; $display("FAIL coll_winner got=%h exp=77", rd_data); end
  endtask

  task automatic test_read_during_write();
    wr_valid = 2'b01; wr_addr = 2'b00; wr_data = 8'h09; rd_addr = 2'b10;
    step();
    checks++; if (rd_data !== 8'h73) begin failures++; $display("FAIL rdw_old got=%h exp=73", rd_data); end
    wr_valid = 2'b00;
    step();
    checks++; if (rd_data !== 8'h79) begin failures++; $display("FAIL rdw_new got=%h exp=79", rd_data); end
  endtask

  task automatic test_out_of_range();
    b_wr_valid = 1'b1; b_wr_addr = 2'd3; b_wr_data = 4'h5; b_rd_addr = 2'd3;
    step();
    b_wr_valid = 1'b0;
    checks++; if (b_rd_data !== 4'h0) begin failures++; $display("FAIL oor_read got=%h exp=0", b_rd_data); end
    b_rd_addr = 2'd2;
    step();
    checks++; if (b_rd_data !== 4'hA) begin failures++; $display("FAIL oor_no_alias got=%h exp=a", b_rd_data); end
  endtask

  task automatic test_init_req();
    wr_valid = 2'b01; wr_addr = 2'b00; wr_data = 8'h03;
    step();
    wr_valid = 2'b00; init_req = 1; rd_addr = 2'b00;
    step();
    checks++; if (rd_data[3:0] !== 4'h3) begin failures++; $display("FAIL init_prewrite got=%h exp=3", rd_data[3:0]); end
    checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL init_busy0 got=%0b exp=1", init_busy); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL init_ready0 got=%0b exp=0", wr_ready); end
    wr_valid = 2'b11; wr_addr = 2'b10; wr_data = 8'h66;
    step();
    checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL init_busy1 got=%0b exp=1", init_busy); end
    step();
    checks++; if (init_busy !== 1'b0) begin failures++; $display("FAIL init_no_restart got=%0b exp=0", init_busy); end
    wr_valid = 2'b00; init_req = 0; rd_addr = 2'b10;
    step();
    checks++; if (rd_data !== 8'hAA) begin failures++; $display("FAIL init_refill got=%h exp=aa", rd_data); end
    checks++; if (init_busy !== 1'b0) begin failures++; $display("FAIL init_idle got=%0b exp=0", init_busy); end
  endtask

`ifdef MEMWR_LANE_EN
  task automatic test_lane();
    wr_valid = 2'b01; wr_addr = 2'b01; wr_data = 8'h05; wr_lane = 4'b0001; rd_addr = 2'b01;
    step();
    wr_valid = 2'b00; wr_lane = 4'b1111;
    step();
    checks++; if (rd_data[3:0] !== 4'h9) begin failures++; $display("FAIL lane_merge got=%h exp=9", rd_data[3:0]); end
  endtask
`endif

  task automatic test_reset_mid_fill();
    rd_addr = 2'b10; init_req = 1;
    step();
    init_req = 0;
    step();
    rst_n = 0;
    #1;
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL midrst_rd got=%h exp=00", rd_data); end
    checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL midrst_busy got=%0b exp=1", init_busy); end
    step();
    rst_n = 1;
    step();
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL midrst_cleared got=%h exp=00", rd_data); end
    checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL midrst_busy1 got=%0b exp=1", init_busy); end
    step();
    checks++; if (rd_data !== 8'h0A) begin failures++; $display("FAIL midrst_entry0 got=%h exp=0a", rd_data); end
    checks++; if (init_busy !== 1'b0) begin failures++; $display("FAIL midrst_done got=%0b exp=0", init_busy); end
    step();
    checks++; if (rd_data !== 8'hAA) begin failures++; $display("FAIL midrst_refill got=%h exp=aa", rd_data); end
  endtask

  initial begin
    test_reset();
    test_parallel_write();
    test_collision();
    test_read_during_write();
    test_out_of_range();
    test_init_req();
`ifdef MEMWR_LANE_EN
    test_lane();
`endif
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memwr_port_bank.md
MEMWR_PORT_BANK -- requirements
Module: memwr_port_bank

Interface
- REQ-001: Parameter WIDTH, default 4, word width in bits.
- REQ-002: Parameter DEPTH, default 2, number of array entries; AW = max(1, clog2(DEPTH)).
- REQ-003: Parameter NCH, default 2, number of independent write and read channels.
- REQ-004: Parameter LANES, default 2, sub-word lanes per word; WIDTH SHALL be divisible by LANES; LW = WIDTH/LANES.
- REQ-005: Parameter FILL_VAL, default 4'hA (WIDTH bits), value written to every entry by the fill sequence.
- REQ-006: clk  in  1  sole clock; all state updates on its rising edge.
- REQ-007: rst_n  in  1  asynchronous, active-low reset.
- REQ-008: init_req  in  1  request to re-run the fill sequence.
- REQ-009: init_busy  out  1  high while the fill sequence runs.
- REQ-010: wr_valid  in  NCH  per-channel write strobe.
- REQ-011: wr_addr  in  NCH*AW  per-channel write address; channel c occupies bits [c*AW +: AW].
- REQ-012: wr_data  in  NCH*WIDTH  per-channel write data; channel c at [c*WIDTH +: WIDTH].
- REQ-013: wr_lane  in  NCH*LANES  per-channel lane enables; present only with MEMWR_LANE_EN.
- REQ-014: wr_ready  out  1  high when writes are accepted.
- REQ-015: rd_addr  in  NCH*AW  per-channel read address.
- REQ-016: rd_data  out  NCH*WIDTH  per-channel registered read data.
- REQ-017: conflict  out  1  one-cycle pulse: two or more accepted writes hit the same entry (same lane) in the previous cycle.

Function
- REQ-018: State machine has states FILL and IDLE; no other states.
- REQ-019: FILL writes FILL_VAL to entry fill_ptr each cycle; fill_ptr advances 0..DEPTH-1; on the cycle writing DEPTH-1, next state is IDLE.
- REQ-020: FILL lasts exactly DEPTH cycles; init_busy = 1 and wr_ready = 0 throughout FILL.
- REQ-021: In IDLE, init_req = 1 moves to FILL with fill_ptr = 0 on the next edge; the write accepted in that same cycle still takes effect first.
- REQ-022: init_req during FILL is ignored; the sequence does not restart.
- REQ-023: In IDLE, a write on channel c is accepted when wr_valid[c] = 1; entry wr_addr[c] is updated at the next edge.
- REQ-024: Writes presented during FILL are dropped, with no deferred effect.
- REQ-025: Addresses >= DEPTH: writes are dropped; reads return 0.
- REQ-026: Same-entry write collision: highest-numbered channel wins, per lane; conflict pulses high for one cycle after the collision.
- REQ-027: Read latency is 1 cycle: rd_data[c] equals the entry contents before the edge at which rd_addr[c] was sampled.
- REQ-028: Read-during-write to the same entry returns old data.

Reset
- REQ-029: While rst_n = 0: all entries = 0, rd_data = 0, conflict = 0, state = FILL, fill_ptr = 0, init_busy = 1, wr_ready = 0.
- REQ-030: The first fill write occurs on the first rising clk after rst_n deasserts.
- REQ-031: Reset asserted mid-FILL or mid-write aborts the operation immediately; fill restarts from entry 0 after deassertion.

Configuration
- REQ-032: Macro MEMWR_LANE_EN defined: wr_lane exists; only lanes l with wr_lane[c*LANES+l] = 1 are written (bits [l*LW +: LW]); collision detection is per lane.
- REQ-033: MEMWR_LANE_EN undefined: no wr_lane port; every accepted write replaces the full word; LANES is unused.

Verification (defaults WIDTH=4, DEPTH=2, NCH=2, LANES=2)
- REQ-034: Release reset, idle inputs -> init_busy high 2 cycles then low; reads of entries 0 and 1 return 4'hA.
- REQ-035: IDLE, ch0 writes 4'h3 to addr0 and ch1 writes 4'h5 to addr1 in one cycle -> next-cycle reads give 4'h3 and 4'h5; conflict stays 0.
- REQ-036: IDLE, ch0 writes 4'h1 and ch1 writes 4'h7 to addr1 in one cycle -> entry1 = 4'h7; conflict pulses for exactly one cycle.
- REQ-037: With MEMWR_LANE_EN, entry1 = 4'hA, ch0 writes 4'h5 with wr_lane = 2'b01 -> entry1 = 4'h9.
- REQ-038: init_req pulse after writing 4'h3 to addr0 -> 2 busy cycles; write during busy is dropped; both entries read 4'hA afterwards.
- REQ-039: rst_n asserted after the first fill cycle -> rd_data = 0 immediately; after release, full 2-cycle fill completes and both entries read 4'hA.
